// File: rtl/cp0_pkg.sv
// Shared constants for the coprocessor-0 block: register numbers, exception codes
// and SR/Cause field positions.
package cp0_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  localparam int SR_IE_BIT     = 0;
  localparam int SR_EXL_BIT    = 1;
  localparam int SR_IM_LSB     = 10;
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_TI_BIT  = 30;
  localparam int CAUSE_BD_BIT  = 31;

  // EPC always holds a word-aligned address.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with a sticky pending flag; only instantiated when the
// CP0_TIMER_EN build option is defined.
module cp0_timer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;

  // Next-state: a Compare write clears the pending flag even on a match cycle.
  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (count_we_i) begin
      count_d = wdata_i;
    end else begin
      count_d = count_q + 32'd1;
    end
    if (compare_we_i) begin
      compare_d = wdata_i;
      ti_d      = 1'b0;
    end else if (count_q == compare_q) begin
      ti_d = 1'b1;
    end else begin
      ti_d = ti_q;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0: SR/Cause/EPC/PRId, exception/interrupt request generation.
// Build option CP0_TIMER_EN adds Count(9)/Compare(11) and the Cause.TI source.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h4255_4141,
  parameter int          HWINT_W    = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         A1,
  input  logic [4:0]         A2,
  input  logic [31:0]        Din,
  input  logic               en,
  input  logic               EXLClr,
  input  logic [31:0]        VPC,
  input  logic               BDIn,
  input  logic [4:0]         ExcCodeIn,
  input  logic [HWINT_W-1:0] HWInt,
  output logic [31:0]        CP0Out,
  output logic [31:0]        EPCOut,
  output logic               Req
);

  logic [HWINT_W-1:0] im_q, im_d;
  logic [HWINT_W-1:0] ip_q, ip_d;
  logic               ie_q, ie_d;
  logic               exl_q, exl_d;
  logic               bd_q, bd_d;
  logic [4:0]         exc_code_q, exc_code_d;
  logic [31:0]        epc_q, epc_d;

  logic        int_req_s, exc_req_s, req_s, wr_en_s;
  logic        ti_s;
  logic [31:0] count_s, compare_s;
  logic [31:0] sr_word_s, cause_word_s, rd_data_s;

  assign int_req_s = ie_q & ~exl_q & ((|(HWInt & im_q)) | (ti_s & im_q[HWINT_W-1]));
  assign exc_req_s = (ExcCodeIn != 5'd0) & ~exl_q;
  assign req_s     = int_req_s | exc_req_s;
  // The faulting instruction must not leave a side effect, so Req vetoes its mtc0.
  assign wr_en_s   = en & ~req_s;

`ifdef CP0_TIMER_EN
  cp0_timer u_timer (
    .clk_i        (clk),
    .rst_ni       (reset),
    .count_we_i   (wr_en_s && (A2 == CP0_COUNT)),
    .compare_we_i (wr_en_s && (A2 == CP0_COMPARE)),
    .wdata_i      (Din),
    .count_o      (count_s),
    .compare_o    (compare_s),
    .ti_o         (ti_s)
  );
`else
  assign ti_s      = 1'b0;
  assign count_s   = 32'd0;
  assign compare_s = 32'd0;
`endif

  // Next-state: exception entry, then eret, then mtc0 (eret still lets the write land).
  always_comb begin
    im_d       = im_q;
    ie_d       = ie_q;
    exl_d      = exl_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    ip_d       = HWInt;
    if (req_s) begin
      exl_d      = 1'b1;
      bd_d       = BDIn;
      exc_code_d = int_req_s ? EXC_INT : ExcCodeIn;
      epc_d      = word_align(BDIn ? (VPC - 32'd4) : VPC);
    end else begin
      if (wr_en_s && (A2 == CP0_SR)) begin
        im_d  = Din[SR_IM_LSB +: HWINT_W];
        exl_d = Din[SR_EXL_BIT];
        ie_d  = Din[SR_IE_BIT];
      end else begin
        im_d = im_q;
      end
      if (wr_en_s && (A2 == CP0_EPC)) begin
        epc_d = word_align(Din);
      end else begin
        epc_d = epc_q;
      end
      if (EXLClr) begin
        exl_d = 1'b0;
      end else begin
        exl_d = exl_d;
      end
    end
  end

  // Architectural state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q       <= '0;
      ip_q       <= '0;
      ie_q       <= 1'b0;
      exl_q      <= 1'b0;
      bd_q       <= 1'b0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      im_q       <= im_d;
      ip_q       <= ip_d;
      ie_q       <= ie_d;
      exl_q      <= exl_d;
      bd_q       <= bd_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  // Assemble the architected register views and the mfc0 read mux.
  always_comb begin
    sr_word_s                             = 32'd0;
    sr_word_s[SR_IM_LSB +: HWINT_W]       = im_q;
    sr_word_s[SR_EXL_BIT]                 = exl_q;
    sr_word_s[SR_IE_BIT]                  = ie_q;
    cause_word_s                          = 32'd0;
    cause_word_s[CAUSE_BD_BIT]            = bd_q;
    cause_word_s[CAUSE_TI_BIT]            = ti_s;
    cause_word_s[CAUSE_IP_LSB +: HWINT_W] = ip_q;
    cause_word_s[CAUSE_EXC_LSB +: 5]      = exc_code_q;
    case (A1)
      CP0_SR:      rd_data_s = sr_word_s;
      CP0_CAUSE:   rd_data_s = cause_word_s;
      CP0_EPC:     rd_data_s = epc_q;
      CP0_PRID:    rd_data_s = PRID_VALUE;
      CP0_COUNT:   rd_data_s = count_s;
      CP0_COMPARE: rd_data_s = compare_s;
      default:     rd_data_s = 32'd0;
    endcase
  end

  assign CP0Out = rd_data_s;
  assign EPCOut = epc_q;
  assign Req    = req_s;

endmodule
